// File: rtl/step_pkg.sv
// Shared stepper definitions: half-step pattern table, pattern lookup and
// decoder state encoding. The stepper driver uses the same table.
package step_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_TRACK = 2'd1;
   localparam logic [1:0] ST_FAULT = 2'd2;

   // Half-step sequence, index 0 in the least significant nibble.
   localparam logic [31:0] PATTERN_TABLE = {
      4'b1001, 4'b1000, 4'b1100, 4'b0100,
      4'b0110, 4'b0010, 4'b0011, 4'b0001
   };

   typedef struct packed {
      logic       legal;
      logic [2:0] idx;
   } phase_idx_t;

   function automatic logic [3:0] pattern_of(input logic [2:0] idx);
      return PATTERN_TABLE[{idx, 2'b00} +: 4];
   endfunction

   // Reverse lookup; legal stays low for 0000 and for any off-table pattern.
   function automatic phase_idx_t pattern_to_index(input logic [3:0] pattern);
      phase_idx_t r;
      r.legal = 1'b0;
      r.idx   = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (pattern_of(3'(i)) == pattern) begin
            r.legal = 1'b1;
            r.idx   = 3'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/phase_filter.sv
// Two-flop synchroniser followed by a stability filter: the filtered pattern
// takes a new value only after it has been seen for FilterLen clocks in a row.
module phase_filter #(
   parameter logic [7:0] FilterLen = 8'd16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] phase_raw,
   output logic [3:0] pattern,
   output logic       change
);

   logic [3:0] sync_a;
   logic [3:0] sync_b;
   logic [3:0] cand;
   logic [7:0] count;

   // Bring the asynchronous winding lines into the clk domain.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_a <= 4'b0000;
         sync_b <= 4'b0000;
      end else begin
         sync_a <= phase_raw;
         sync_b <= sync_a;
      end
   end

   // Count consecutive sightings of a candidate pattern; any different
   // value restarts the count, so short glitches never reach the output.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cand    <= 4'b0000;
         count   <= 8'd0;
         pattern <= 4'b0000;
         change  <= 1'b0;
      end else begin
         change <= 1'b0;
         if (sync_b == pattern) begin
            cand  <= sync_b;
            count <= 8'd0;
         end else if (sync_b != cand) begin
            cand <= sync_b;
            if (FilterLen == 8'd1) begin
               pattern <= sync_b;
               change  <= 1'b1;
               count   <= 8'd0;
            end else begin
               count <= 8'd1;
            end
         end else if (count >= FilterLen - 8'd1) begin
            pattern <= sync_b;
            change  <= 1'b1;
            count   <= 8'd0;
         end else begin
            count <= count + 8'd1;
         end
      end
   end

endmodule

// File: rtl/step_decode.sv
// Half-step stepper phase decoder: tracks position, direction and step
// period from filtered winding patterns.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | windings off or just cleared; waits for a legal pattern
// ST_TRACK | locked to a table index, counting +/-1 steps
// ST_FAULT | illegal pattern or skipped step seen; waits for ClearErr
module step_decode
   import step_pkg::*;
#(
   parameter logic [7:0]  FilterLen     = 8'd16,
   parameter logic [23:0] TimeoutCycles = 24'd1000000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         PhaseIn,
   input  logic               ClearErr,
   output logic signed [15:0] Position,
   output logic               StepPulse,
   output logic               DirOut,
   output logic [23:0]        StepPeriod,
   output logic               Stalled,
   output logic               Error,
   output logic               Tracking
);

   logic [3:0]  filt;
   logic        filt_change;
   logic [1:0]  state,      state_nxt;
   logic [2:0]  idx,        idx_nxt;
   logic [23:0] period_cnt, cnt_nxt;
   logic signed [15:0] pos_nxt;
   logic        dir_nxt;
   logic        step_nxt;
   logic [23:0] period_nxt;
   logic [2:0]  delta;
   phase_idx_t  lookup;

   phase_filter #(.FilterLen(FilterLen)) u_filter (
      .clk       (clk),
      .rst       (rst),
      .phase_raw (PhaseIn),
      .pattern   (filt),
      .change    (filt_change)
   );

   assign Tracking = (state == ST_TRACK);
   assign Error    = (state == ST_FAULT);

   // Next-state and step decision from the filtered pattern.
   always_comb begin
      state_nxt  = state;
      idx_nxt    = idx;
      pos_nxt    = Position;
      dir_nxt    = DirOut;
      step_nxt   = 1'b0;
      period_nxt = StepPeriod;
      cnt_nxt    = (period_cnt == 24'hFFFFFF) ? period_cnt : period_cnt + 24'd1;
      lookup     = pattern_to_index(filt);
      delta      = lookup.idx - idx;
      case (state)
         ST_IDLE: begin
            if (filt != 4'b0000) begin
               if (lookup.legal) begin
                  state_nxt = ST_TRACK;
                  idx_nxt   = lookup.idx;
                  cnt_nxt   = 24'd1;
               end else begin
                  state_nxt = ST_FAULT;
               end
            end
         end
         ST_TRACK: begin
            if (filt_change) begin
               if (filt == 4'b0000) begin
                  state_nxt = ST_IDLE;
               end else if (lookup.legal && (delta == 3'd1 || delta == 3'd7)) begin
                  step_nxt   = 1'b1;
                  idx_nxt    = lookup.idx;
                  dir_nxt    = (delta == 3'd1);
                  pos_nxt    = (delta == 3'd1) ? Position + 16'sd1 : Position - 16'sd1;
                  period_nxt = period_cnt;
                  cnt_nxt    = 24'd1;
               end else begin
                  state_nxt = ST_FAULT;
               end
            end
         end
         ST_FAULT: begin
            if (ClearErr) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Register state and outputs; Stalled is evaluated on the values being
   // loaded so it drops on the same clock as the step that ends the stall.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         period_cnt <= 24'd0;
         Position   <= 16'sd0;
         StepPulse  <= 1'b0;
         DirOut     <= 1'b1;
         StepPeriod <= 24'd0;
         Stalled    <= 1'b0;
      end else begin
         state      <= state_nxt;
         idx        <= idx_nxt;
         period_cnt <= cnt_nxt;
         Position   <= pos_nxt;
         StepPulse  <= step_nxt;
         DirOut     <= dir_nxt;
         StepPeriod <= period_nxt;
         Stalled    <= (state_nxt == ST_TRACK) && (cnt_nxt >= TimeoutCycles);
      end
   end

endmodule

// File: tb/tb_step_decode.sv
module tb_step_decode;

   typedef struct {
      logic        dir;
      logic [15:0] pos;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  PhaseIn;
   logic        ClearErr;
   logic [15:0] Position;
   logic        StepPulse, DirOut, Stalled, Error, Tracking;
   logic [23:0] StepPeriod;

   logic        w_rst;
   logic [3:0]  w_phase;
   logic [15:0] w_pos;
   logic        w_pulse, w_dir, w_stalled, w_error, w_tracking;
   logic [23:0] w_period;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc   = 0;
   exp_t        sb[$];
   logic [15:0] pos_model;
   logic [3:0]  tbl [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                            4'b0100, 4'b1100, 4'b1000, 4'b1001};

   step_decode #(.FilterLen(8'd4), .TimeoutCycles(24'd50)) u_dut (
      .clk(clk), .rst(rst), .PhaseIn(PhaseIn), .ClearErr(ClearErr),
      .Position(Position), .StepPulse(StepPulse), .DirOut(DirOut),
      .StepPeriod(StepPeriod), .Stalled(Stalled), .Error(Error), .Tracking(Tracking)
   );

   step_decode #(.FilterLen(8'd1)) u_wrap (
      .clk(clk), .rst(w_rst), .PhaseIn(w_phase), .ClearErr(1'b0),
      .Position(w_pos), .StepPulse(w_pulse), .DirOut(w_dir),
      .StepPeriod(w_period), .Stalled(w_stalled), .Error(w_error), .Tracking(w_tracking)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_neg(input int n);
      repeat (n) @(negedge clk);
   endtask

   // kind: 0 no step expected, 1 forward step, -1 backward step
   task automatic set_phase(input logic [3:0] p, input int kind);
      exp_t e;
      PhaseIn = p;
      if (kind != 0) begin
         pos_model = (kind > 0) ? pos_model + 16'd1 : pos_model - 16'd1;
         e.dir = (kind > 0);
         e.pos = pos_model;
         e.due = cyc + 7;
         sb.push_back(e);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_pos"},    32'(Position),   32'h0);
      chk({tag, "_pulse"},  32'(StepPulse),  32'h0);
      chk({tag, "_dir"},    32'(DirOut),     32'h1);
      chk({tag, "_period"}, 32'(StepPeriod), 32'h0);
      chk({tag, "_stall"},  32'(Stalled),    32'h0);
      chk({tag, "_err"},    32'(Error),      32'h0);
      chk({tag, "_track"},  32'(Tracking),   32'h0);
   endtask

   // Scoreboard: every StepPulse must match the oldest queued expectation.
   always @(negedge clk) begin : mon
      exp_t e;
      if (StepPulse) begin
         chk("step_expected", 32'(sb.size() != 0), 32'h1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("step_cycle", 32'(cyc), 32'(e.due));
            chk("step_pos", 32'(Position), 32'(e.pos));
            chk("step_dir", 32'(DirOut), 32'(e.dir));
         end
      end
   end

   initial begin
      rst = 1'b0; PhaseIn = 4'b0000; ClearErr = 1'b0; pos_model = 16'd0;
      w_rst = 1'b0; w_phase = 4'b0001;
      wait_neg(2);
      chk_reset_values("reset");
      rst = 1'b1; w_rst = 1'b1;

      // forward acquisition and two steps 100 clocks apart
      set_phase(4'b0001, 0);  wait_neg(100);
      chk("acq_track", 32'(Tracking), 32'h1);
      set_phase(4'b0011, 1);  wait_neg(100);
      set_phase(4'b0010, 1);  wait_neg(100);
      chk("fwd_pos", 32'(Position), 32'(pos_model));
      chk("fwd_dir", 32'(DirOut), 32'h1);
      chk("fwd_period", 32'(StepPeriod), 32'd100);

      // backward through index 0 into negative positions
      set_phase(4'b0011, -1); wait_neg(20);
      set_phase(4'b0001, -1); wait_neg(20);
      set_phase(4'b1001, -1); wait_neg(20);
      set_phase(4'b1000, -1); wait_neg(20);
      chk("back_pos", 32'(Position), 32'hFFFE);
      chk("back_dir", 32'(DirOut), 32'h0);
      chk("back_period", 32'(StepPeriod), 32'd20);

      // return to 0001, then a 3-clock glitch must be rejected
      set_phase(4'b1001, 1);  wait_neg(20);
      set_phase(4'b0001, 1);  wait_neg(20);
      set_phase(4'b0011, 0);  wait_neg(3);
      set_phase(4'b0001, 0);  wait_neg(20);
      chk("glitch_pos", 32'(Position), 32'h0);
      chk("glitch_track", 32'(Tracking), 32'h1);

      // windings off, re-acquire, stall timing
      set_phase(4'b0000, 0);  wait_neg(10);
      chk("off_track", 32'(Tracking), 32'h0);
      set_phase(4'b0001, 0);  wait_neg(6);
      chk("acq_latency_pre", 32'(Tracking), 32'h0);
      wait_neg(1);
      chk("acq_latency", 32'(Tracking), 32'h1);
      wait_neg(48);
      chk("stall_pre", 32'(Stalled), 32'h0);
      wait_neg(1);
      chk("stall_rise", 32'(Stalled), 32'h1);
      wait_neg(11);
      set_phase(4'b0011, 1);  wait_neg(6);
      chk("stall_hold", 32'(Stalled), 32'h1);
      wait_neg(1);
      chk("stall_fall", 32'(Stalled), 32'h0);
      chk("stall_period", 32'(StepPeriod), 32'd67);
      set_phase(4'b0000, 0);  wait_neg(10);
      chk("idle_track", 32'(Tracking), 32'h0);
      chk("idle_pos", 32'(Position), 32'(pos_model));
      chk("idle_period", 32'(StepPeriod), 32'd67);

      // skipped step -> fault, clear, re-acquire without a step
      set_phase(4'b0001, 0);  wait_neg(20);
      set_phase(4'b0110, 0);  wait_neg(20);
      chk("skip_err", 32'(Error), 32'h1);
      chk("skip_pos", 32'(Position), 32'(pos_model));
      ClearErr = 1'b1; wait_neg(1); ClearErr = 1'b0;
      chk("clear_idle_err", 32'(Error), 32'h0);
      chk("clear_idle_track", 32'(Tracking), 32'h0);
      wait_neg(1);
      chk("reacq_track", 32'(Tracking), 32'h1);
      ClearErr = 1'b1; wait_neg(2); ClearErr = 1'b0;
      chk("clear_in_track", 32'(Tracking), 32'h1);
      set_phase(4'b0010, -1); wait_neg(20);
      chk("after_reacq_pos", 32'(Position), 32'(pos_model));
      chk("after_reacq_dir", 32'(DirOut), 32'h0);

      // illegal pattern; clearing while it persists faults again
      set_phase(4'b0101, 0);  wait_neg(20);
      chk("illegal_err", 32'(Error), 32'h1);
      ClearErr = 1'b1; wait_neg(1); ClearErr = 1'b0;
      chk("illegal_clear", 32'(Error), 32'h0);
      wait_neg(1);
      chk("illegal_refault", 32'(Error), 32'h1);
      set_phase(4'b0001, 0);  wait_neg(20);
      chk("fault_ignores_change", 32'(Error), 32'h1);
      ClearErr = 1'b1; wait_neg(1); ClearErr = 1'b0;
      wait_neg(1);
      chk("fault_reacq", 32'(Tracking), 32'h1);
      chk("fault_reacq_pos", 32'(Position), 32'(pos_model));

      // reset in the middle of a pending step
      set_phase(4'b0011, 0);  wait_neg(3);
      rst = 1'b0; #1;
      chk_reset_values("midrst");
      wait_neg(1);
      rst = 1'b1; pos_model = 16'd0;
      wait_neg(12);
      chk("post_rst_track", 32'(Tracking), 32'h1);
      chk("post_rst_pos", 32'(Position), 32'h0);
      chk("sb_drained", 32'(sb.size()), 32'h0);

      // wrap instance: one forward step per clock up to 32767, then wrap
      for (int i = 1; i <= 32767; i++) begin
         w_phase = tbl[i % 8];
         wait_neg(1);
      end
      wait_neg(10);
      chk("wrap_max", 32'(w_pos), 32'h7FFF);
      w_phase = tbl[0];
      wait_neg(10);
      chk("wrap_min", 32'(w_pos), 32'h8000);
      chk("wrap_dir", 32'(w_dir), 32'h1);
      w_rst = 1'b0; #1;
      chk("wrap_rst_pos", 32'(w_pos), 32'h0);
      chk("wrap_rst_track", 32'(w_tracking), 32'h0);
      wait_neg(1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/step_decode.md
STEP_DECODE -- requirements
Module: step_decode

Interface
REQ-001 Parameter FilterLen, default 8'd16, number of consecutive stable clocks required to accept a phase pattern (1..255).
REQ-002 Parameter TimeoutCycles, default 24'd1000000, step-period threshold above which Stalled asserts.
REQ-003 clk  input  1  system clock, ~50 MHz; the block uses this single clock only.
REQ-004 rst  input  1  asynchronous, active-low reset.
REQ-005 PhaseIn  input  4  winding drive lines observed from a half-step driver (asynchronous to clk).
REQ-006 ClearErr  input  1  synchronous, level; leaves FAULT.
REQ-007 Position  output  16  signed two's-complement step count.
REQ-008 StepPulse  output  1  one-clock pulse per accepted step.
REQ-009 DirOut  output  1  direction of last accepted step: 1 = forward, 0 = backward.
REQ-010 StepPeriod  output  24  clocks between the last two accepted steps.
REQ-011 Stalled  output  1  TRACK held with no step for at least TimeoutCycles clocks.
REQ-012 Error  output  1  high while in FAULT.
REQ-013 Tracking  output  1  high while in TRACK.

Function
REQ-014 PhaseIn is synchronised through 2 flops; the filtered pattern updates only after the synchronised value is unchanged for FilterLen consecutive clocks.
REQ-015 Pattern table, index 0..7: 0001, 0011, 0010, 0110, 0100, 1100, 1000, 1001; any other nonzero pattern is illegal; 0000 means windings off.
REQ-016 States: IDLE, TRACK, FAULT.
REQ-017 IDLE: on any clock where the filtered pattern is a legal pattern -> TRACK; latch its index; no StepPulse; PeriodCnt <= 1. If the filtered pattern is 0000, stay in IDLE. If it is illegal -> FAULT.
REQ-018 TRACK, filtered change: delta = (new - old) mod 8. delta 1 -> forward step; delta 7 -> backward step. On a step: StepPulse = 1, Position +/-1, DirOut updated, index updated.
REQ-019 TRACK, filtered pattern 0000 -> IDLE, with Position, DirOut and StepPeriod retained.
REQ-020 TRACK, illegal pattern or delta 2..6 -> FAULT, with Position and index unchanged and no StepPulse.
REQ-021 FAULT: ClearErr = 1 -> IDLE on the next clock. ClearErr is ignored in IDLE and TRACK.
REQ-022 Filtered changes arriving in FAULT are ignored. After a clear, IDLE re-acquires from the current filtered pattern.
REQ-023 Position wraps modulo 2^16 (32767 + 1 = -32768) without a flag.
REQ-024 PeriodCnt is 24 bits, increments every clock, and saturates at 24'hFFFFFF. On a step: StepPeriod <= PeriodCnt and PeriodCnt <= 1, so steps N clocks apart report N.
REQ-025 Stalled = Tracking AND (PeriodCnt >= TimeoutCycles), registered; it clears on the step clock.
REQ-026 Latency from a PhaseIn edge to StepPulse is exactly FilterLen + 3 clocks.
REQ-027 A PhaseIn glitch shorter than FilterLen clocks (after synchronisation) produces no filtered change.

Reset
REQ-028 On rst = 0, asynchronously: state IDLE, Position 0, StepPulse 0, DirOut 1, StepPeriod 0, PeriodCnt 0, Stalled 0, Error 0, Tracking 0, synchroniser and filtered pattern 4'b0000, filter counter 0.
REQ-029 Reset asserted mid-step overrides all other events; the first acquisition after release follows REQ-017.

Structure
REQ-030 The shared package step_pkg holds the 8-entry pattern table, the pattern-to-index function, and the state encoding constants; the existing stepper driver uses the same table.
REQ-031 One sub-module, phase_filter (2-flop synchroniser plus stability counter), outputs the filtered 4-bit pattern and a one-clock change strobe.

Verification
REQ-032 FilterLen = 4: drive the forward sequence 0001 -> 0011 -> 0010, each held 100 clocks -> Tracking = 1, 2 StepPulses, Position = 2, DirOut = 1, StepPeriod = 100.
REQ-033 Starting at index 0, drive 1001 then 1000 -> Position = -2, DirOut = 0; each StepPulse occurs 7 clocks after its PhaseIn edge.
REQ-034 In TRACK at 0001, drive 0110 -> Error = 1, Position unchanged; pulse ClearErr -> IDLE, then re-acquire 0110 with no step.
REQ-035 Drive a 3-clock glitch 0001 -> 0011 -> 0001 with FilterLen = 4 -> no StepPulse, Position unchanged.
REQ-036 TimeoutCycles = 50: hold a legal pattern for 60 clocks in TRACK -> Stalled rises at clock 50 after acquisition and falls on the next step; drive 0000 -> Tracking = 0 with Position retained.
REQ-037 Preload Position to 32767 via forward steps (or force it) and take one forward step -> Position = -32768; assert rst mid-sequence -> all outputs at their REQ-028 values.
